// File: rtl/uart_tx_arbiter.sv
// Two-source round-robin arbiter feeding a single 8N1 UART transmitter.
// The serial line is registered; ready pulses are combinational in IDLE.
module uart_tx_arbiter #(
  parameter int CLK_PER_BIT = 434,
  parameter int CNT_W       = 16
) (
  input  logic       clk_in,
  input  logic       sys_rstn,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       uart_txd,
  output logic       busy,
  output logic       grant_id,
  output logic       tx_done
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(CLK_PER_BIT - 1);

  state_t     state;
  state_t     state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2:0] idx;
  logic [2:0] idx_nx;
  logic [7:0] data;
  logic       pref1;
  logic       txd;
  logic       txd_nx;
  logic       gnt;
  logic       sel;
  logic       bit_end;

  assign bit_end = (cnt == LAST);
  assign idx_nx  = idx + 3'd1;
  assign gnt = sys_rstn && (state == IDLE)
            && (req0_valid || req1_valid);
  // With both requesting, the loser of the last grant wins.
  assign sel = (req0_valid && req1_valid)
             ? pref1 : req1_valid;

  always_ff @(posedge clk_in) begin
    if (!sys_rstn) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (gnt) state_nx = START;
      START: if (bit_end) state_nx = DATA;
      DATA:  if (bit_end && idx == 3'd7)
               state_nx = STOP;
      STOP:  if (bit_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = gnt && !sel;
    req1_ready = gnt && sel;
    busy       = (state != IDLE) || gnt;
    tx_done    = sys_rstn && (state == STOP)
              && bit_end;
    txd_nx     = txd;
    unique case (state)
      IDLE:  txd_nx = !gnt;
      START: if (bit_end) txd_nx = data[0];
      DATA:
        if (bit_end)
          txd_nx = (idx == 3'd7) ? 1'b1
                 : data[idx_nx];
      STOP:  txd_nx = 1'b1;
      default: txd_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!sys_rstn) begin
      cnt      <= '0;
      idx      <= 3'd0;
      data     <= 8'd0;
      pref1    <= 1'b0;
      grant_id <= 1'b0;
      txd      <= 1'b1;
    end else begin
      txd <= txd_nx;
      // IDLE holds the counter so START always begins at zero.
      if (state == IDLE || bit_end) cnt <= '0;
      else                          cnt <= cnt + 1'b1;
      if (gnt) begin
        data     <= sel ? req1_data : req0_data;
        grant_id <= sel;
        pref1    <= !sel;
        idx      <= 3'd0;
      end
      if (state == DATA && bit_end)
        idx <= idx_nx;
    end
  end

  assign uart_txd = txd;

endmodule
